alu_mdu_ctrl: RTL

- Parametrised successor to the single-cycle ALU control decoder.
- Decodes aluop/funct, executes the result, and adds a multi-cycle signed/unsigned multiplier with HI/LO registers.
- Uses a valid/ready handshake so the datapath stalls while a multiply iterates.
- Sits in the EX stage between the main control unit and the register-file write-back path.

---
 rtl/alu_mdu_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/alu_mdu_ctrl.sv
// alu_mdu_ctrl: EX-stage ALU control decoder with an iterative multiplier
// that keeps its own HI/LO registers.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operation handshake (in_ready is high only in IDLE)
//   aluop, funct        operation select (funct is used when aluop == 2'b10)
//   a, b                operands
//   out_valid           one-cycle result strobe
//   result, zero        registered result and its (result == 0) flag
//   err                 illegal funct, meaningful while out_valid is high
//   alu_ctl             ALU code of the last accepted operation
//   hi, lo              multiplier product registers
//
// state | meaning
// IDLE  | ready; simple ops finish here in one cycle
// MUL   | shift-add, one multiplier bit per cycle, WIDTH cycles
// FIN   | apply sign, write HI/LO, strobe out_valid
module alu_mdu_ctrl #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err,
  output logic [2:0]       alu_ctl,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_SLT = 3'b111;
  localparam logic [2:0] CTL_MUL = 3'b100;

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  state_t state, state_nxt;

  logic             accept;
  logic [WIDTH-1:0] op_res;
  logic [2:0]       op_ctl;
  logic             op_err;
  logic             op_mul;
  logic             op_signed;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [2*WIDTH-1:0] mcand, prod, prod_fin;
  logic [WIDTH-1:0] mplier;
  logic             neg;
  logic [CW-1:0]    cnt;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    op_res    = '0;
    op_ctl    = CTL_ADD;
    op_err    = 1'b0;
    op_mul    = 1'b0;
    op_signed = 1'b0;
    case (aluop)
      2'b00: op_res = a + b;
      2'b01: begin op_res = a - b; op_ctl = CTL_SUB; end
      2'b11: begin op_res = a | b; op_ctl = CTL_OR;  end
      default: begin
        case (funct)
          6'b100000: op_res = a + b;
          6'b100010: begin op_res = a - b; op_ctl = CTL_SUB; end
          6'b100100: begin op_res = a & b; op_ctl = CTL_AND; end
          6'b100101: begin op_res = a | b; op_ctl = CTL_OR;  end
          6'b101010: begin
            op_res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            op_ctl = CTL_SLT;
          end
          6'b011000, 6'b011001: begin
            if (MUL_EN) begin
              op_mul    = 1'b1;
              op_signed = (funct == 6'b011000);
              op_ctl    = CTL_MUL;
            end else begin
              op_err = 1'b1;
            end
          end
          6'b010000: begin
            if (MUL_EN) begin op_res = hi; op_ctl = CTL_MUL; end
            else op_err = 1'b1;
          end
          6'b010010: begin
            if (MUL_EN) begin op_res = lo; op_ctl = CTL_MUL; end
            else op_err = 1'b1;
          end
          default: op_err = 1'b1;
        endcase
      end
    endcase
  end

  // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
  always_comb begin
    mag_a    = (op_signed && a[WIDTH-1]) ? -a : a;
    mag_b    = (op_signed && b[WIDTH-1]) ? -b : b;
    prod_fin = neg ? -prod : prod;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && op_mul) state_nxt = MUL;
      MUL:     if (cnt == '0) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      err       <= 1'b0;
      alu_ctl   <= CTL_ADD;
      hi        <= '0;
      lo        <= '0;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            alu_ctl <= op_ctl;
            if (op_mul) begin
              mcand  <= {{WIDTH{1'b0}}, mag_a};
              mplier <= mag_b;
              prod   <= '0;
              neg    <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              cnt    <= CW'(WIDTH - 1);
            end else begin
              result    <= op_res;
              zero      <= (op_res == '0);
              err       <= op_err;
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
        end
        FIN: begin
          hi        <= prod_fin[2*WIDTH-1:WIDTH];
          lo        <= prod_fin[WIDTH-1:0];
          result    <= prod_fin[WIDTH-1:0];
          zero      <= (prod_fin[WIDTH-1:0] == '0);
          err       <= 1'b0;
          alu_ctl   <= CTL_MUL;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
